// File: rtl/regfile_pkg.sv
// regfile_pkg -- widths and sizes shared by the pipeline stages and the
// register file.
//   REG_ADDR_WIDTH : register index width
//   REG_DATA_WIDTH : register word width
//   REG_NUM        : number of architectural registers
//   REG_LAST       : highest register index (last entry cleared by the sweep)
package regfile_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned REG_NUM        = 2 ** REG_ADDR_WIDTH;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_LAST = REG_ADDR_WIDTH'(REG_NUM - 1);

endpackage

// File: rtl/regfile.sv
// regfile -- 32 x 32 register file with one write port and two
// asynchronous read ports. After reset, every entry is cleared by an
// INIT sweep (one entry per cycle). Once the sweep has finished, the
// block moves to RUN and ready_out is raised.
//
// Ports
//   clk                 : clock, rising edge
//   rst_n               : synchronous active-low reset
//   wen_in/waddr_in/wdata_in : write port from write-back (index 0 discarded)
//   ren1_in/raddr1_in   : read port 1 enable / index
//   rdata1_out          : read port 1 data, combinational, with write bypass
//   ren2_in/raddr2_in   : read port 2 enable / index
//   rdata2_out          : read port 2 data, combinational, with write bypass
//   ready_out           : high in RUN (sweep complete, not in reset)
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | clearing entry[cnt_q] each cycle; reads return 0, writes dropped
// ST_RUN  | normal operation; writes commit, reads bypass same-cycle writes
module regfile
  import regfile_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wen_in,
  input  logic [REG_ADDR_WIDTH-1:0] waddr_in,
  input  logic [REG_DATA_WIDTH-1:0] wdata_in,
  input  logic                      ren1_in,
  input  logic [REG_ADDR_WIDTH-1:0] raddr1_in,
  output logic [REG_DATA_WIDTH-1:0] rdata1_out,
  input  logic                      ren2_in,
  input  logic [REG_ADDR_WIDTH-1:0] raddr2_in,
  output logic [REG_DATA_WIDTH-1:0] rdata2_out,
  output logic                      ready_out
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // No reset on the array so it maps onto distributed RAM.
  logic [REG_DATA_WIDTH-1:0] mem_q [REG_NUM];

  logic                      mem_we;
  logic [REG_ADDR_WIDTH-1:0] mem_waddr;
  logic [REG_DATA_WIDTH-1:0] mem_wdata;
  logic                      active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = waddr_in;
    mem_wdata = wdata_in;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        // Counter stops at the last index rather than wrapping.
        if (cnt_q == REG_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        mem_we = wen_in && (waddr_in != '0);
      end
    endcase
    // A reset edge must never commit anything, not even a sweep write.
    if (!rst_n) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Reads are masked to 0 outside RUN so stale or uninitialised storage
  // is never visible; index 0 is hard-wired to 0.
  assign active    = rst_n && (state_q == ST_RUN);
  assign ready_out = active;

  assign rdata1_out = (!active || !ren1_in || (raddr1_in == '0)) ? '0 :
                      (wen_in && (waddr_in == raddr1_in))        ? wdata_in :
                      mem_q[raddr1_in];

  assign rdata2_out = (!active || !ren2_in || (raddr2_in == '0)) ? '0 :
                      (wen_in && (waddr_in == raddr2_in))        ? wdata_in :
                      mem_q[raddr2_in];

endmodule

// File: tb/tb_regfile.sv
// tb_regfile -- self-checking bench for regfile. Inputs change on the
// falling edge and outputs are sampled 1 time unit later; the reference
// model is a plain array of register values plus a ready flag.
module tb_regfile;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen_in = 1'b0;
  logic [4:0]  waddr_in = '0;
  logic [31:0] wdata_in = '0;
  logic        ren1_in = 1'b0;
  logic [4:0]  raddr1_in = '0;
  logic [31:0] rdata1_out;
  logic        ren2_in = 1'b0;
  logic [4:0]  raddr2_in = '0;
  logic [31:0] rdata2_out;
  logic        ready_out;

  regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen_in     (wen_in),
    .waddr_in   (waddr_in),
    .wdata_in   (wdata_in),
    .ren1_in    (ren1_in),
    .raddr1_in  (raddr1_in),
    .rdata1_out (rdata1_out),
    .ren2_in    (ren2_in),
    .raddr2_in  (raddr2_in),
    .rdata2_out (rdata2_out),
    .ready_out  (ready_out)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model [32];
  bit          ready_m = 1'b0;

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_rd(input logic ren, input logic [4:0] addr);
    if (!ready_m || !rst_n || !ren || addr == 5'd0) return 32'd0;
    if (wen_in && waddr_in == addr) return wdata_in;
    return model[addr];
  endfunction

  // Mirror of what the current cycle's inputs commit at the next edge.
  function automatic void model_commit();
    if (ready_m && rst_n && wen_in && waddr_in != 5'd0) model[waddr_in] = wdata_in;
  endfunction

  task automatic idle_inputs();
    wen_in = 1'b0; waddr_in = '0; wdata_in = '0;
    ren1_in = 1'b0; raddr1_in = '0; ren2_in = 1'b0; raddr2_in = '0;
  endtask

  // Reset, optional INIT-time write at sweep cycle 10, optional second
  // reset at sweep cycle abort_at; then the full sweep must complete.
  task automatic test_reset_sweep(input int abort_at, input bit init_wr);
    int k;
    bit aborted;
    aborted = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    wen_in = 1'b1; waddr_in = 5'd9; wdata_in = $urandom;
    ren1_in = 1'b1; raddr1_in = 5'd5; ren2_in = 1'b1; raddr2_in = 5'd9;
    ready_m = 1'b0;
    #1;
    tests_run++;
    if (ready_out !== 1'b0 || rdata1_out !== 32'd0 || rdata2_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_low: ready=%b rd1=%h rd2=%h expected 0/0/0", ready_out, rdata1_out, rdata2_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (k < 32) begin
      wen_in = 1'b0;
      raddr2_in = 5'($urandom);
      if (init_wr && k == 10) begin
        wen_in = 1'b1; waddr_in = 5'd4; wdata_in = 32'hA5A5A5A5;
      end
      if (!aborted && k == abort_at) begin
        rst_n = 1'b0;
        aborted = 1'b1;
      end
      #1;
      tests_run++;
      if (ready_out !== 1'b0 || rdata1_out !== 32'd0 || rdata2_out !== 32'd0) begin
        tests_failed++;
        $display("FAIL sweep_cycle_%0d: ready=%b rd1=%h rd2=%h expected 0/0/0", k, ready_out, rdata1_out, rdata2_out);
      end
      @(negedge clk);
      if (!rst_n) begin
        rst_n = 1'b1;
        k = 0;
      end else begin
        k++;
      end
    end
    wen_in = 1'b0; raddr2_in = 5'd4;
    ready_m = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    tests_run++;
    if (ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_rise: ready=%b expected 1", ready_out);
    end
    tests_run++;
    if (rdata1_out !== 32'd0 || rdata2_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL post_sweep_read: rd1=%h rd2=%h expected 0/0", rdata1_out, rdata2_out);
    end
  endtask

  task automatic test_write_read();
    logic [4:0]  a;
    logic [31:0] d;
    @(negedge clk);
    idle_inputs();
    wen_in = 1'b1; waddr_in = 5'd3; wdata_in = 32'hDEADBEEF;
    #1; model_commit();
    @(negedge clk);
    idle_inputs();
    ren1_in = 1'b1; raddr1_in = 5'd3; ren2_in = 1'b1; raddr2_in = 5'd3;
    #1;
    tests_run++;
    if (rdata1_out !== 32'hDEADBEEF || rdata2_out !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL write_read_r3: rd1=%h rd2=%h expected deadbeef", rdata1_out, rdata2_out);
    end
    for (int n = 0; n < 20; n++) begin
      a = 5'($urandom_range(1, 31));
      d = $urandom;
      @(negedge clk);
      idle_inputs();
      wen_in = 1'b1; waddr_in = a; wdata_in = d;
      #1; model_commit();
      @(negedge clk);
      idle_inputs();
      ren1_in = 1'b1; raddr1_in = a; ren2_in = 1'b1; raddr2_in = 5'($urandom);
      #1;
      tests_run++;
      if (rdata1_out !== d || rdata2_out !== exp_rd(ren2_in, raddr2_in)) begin
        tests_failed++;
        $display("FAIL write_read_rand r%0d: rd1=%h rd2=%h expected %h %h", a, rdata1_out, rdata2_out, d, exp_rd(ren2_in, raddr2_in));
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle_inputs();
    wen_in = 1'b1; waddr_in = 5'd7; wdata_in = 32'h12345678;
    ren1_in = 1'b1; raddr1_in = 5'd7; ren2_in = 1'b0; raddr2_in = 5'd7;
    #1;
    tests_run++;
    if (rdata1_out !== 32'h12345678 || rdata2_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL bypass_r7: rd1=%h rd2=%h expected 12345678 00000000", rdata1_out, rdata2_out);
    end
    model_commit();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      wen_in = 1'b1; waddr_in = 5'($urandom_range(1, 31)); wdata_in = $urandom;
      ren1_in = 1'b1; raddr1_in = waddr_in; ren2_in = 1'b1; raddr2_in = waddr_in;
      #1;
      tests_run++;
      if (rdata1_out !== wdata_in || rdata2_out !== wdata_in) begin
        tests_failed++;
        $display("FAIL bypass_both r%0d: rd1=%h rd2=%h expected %h", waddr_in, rdata1_out, rdata2_out, wdata_in);
      end
      model_commit();
    end
  endtask

  task automatic test_r0();
    @(negedge clk);
    idle_inputs();
    wen_in = 1'b1; waddr_in = 5'd0; wdata_in = 32'hFFFFFFFF;
    ren1_in = 1'b1; raddr1_in = 5'd0; ren2_in = 1'b1; raddr2_in = 5'd0;
    #1;
    tests_run++;
    if (rdata1_out !== 32'd0 || rdata2_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL r0_same_cycle: rd1=%h rd2=%h expected 0", rdata1_out, rdata2_out);
    end
    model_commit();
    @(negedge clk);
    wen_in = 1'b0;
    #1;
    tests_run++;
    if (rdata1_out !== 32'd0 || rdata2_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL r0_after: rd1=%h rd2=%h expected 0", rdata1_out, rdata2_out);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      idle_inputs();
      wen_in = 1'b1; waddr_in = 5'(i); wdata_in = 32'(i);
      #1; model_commit();
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      idle_inputs();
      ren1_in = 1'b1; raddr1_in = 5'(i); ren2_in = 1'b1; raddr2_in = 5'(31 - i);
      #1;
      tests_run++;
      if (rdata1_out !== 32'(i) || rdata2_out !== ((i == 31) ? 32'd0 : 32'(31 - i))) begin
        tests_failed++;
        $display("FAIL fill_read r%0d: rd1=%h rd2=%h expected %h %h", i, rdata1_out, rdata2_out, 32'(i), 32'(31 - i));
      end
    end
  endtask

  task automatic test_all_zero(input int tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      idle_inputs();
      ren1_in = 1'b1; raddr1_in = 5'(i); ren2_in = 1'b1; raddr2_in = 5'(i);
      #1;
      tests_run++;
      if (rdata1_out !== 32'd0 || rdata2_out !== 32'd0) begin
        tests_failed++;
        $display("FAIL all_zero_%0d r%0d: rd1=%h rd2=%h expected 0", tag, i, rdata1_out, rdata2_out);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      wen_in   = 1'($urandom_range(0, 1));
      waddr_in = 5'($urandom);
      wdata_in = $urandom;
      ren1_in  = ($urandom_range(0, 7) != 0);
      ren2_in  = ($urandom_range(0, 7) != 0);
      raddr1_in = ($urandom_range(0, 3) == 0) ? waddr_in : 5'($urandom);
      raddr2_in = ($urandom_range(0, 3) == 0) ? raddr1_in : 5'($urandom);
      #1;
      e1 = exp_rd(ren1_in, raddr1_in);
      e2 = exp_rd(ren2_in, raddr2_in);
      tests_run++;
      if (rdata1_out !== e1 || rdata2_out !== e2 || ready_out !== 1'b1) begin
        tests_failed++;
        $display("FAIL random_%0d: rd1=%h rd2=%h ready=%b expected %h %h 1", n, rdata1_out, rdata2_out, ready_out, e1, e2);
      end
      model_commit();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    test_reset_sweep(-1, 1'b0);
    test_write_read();
    test_bypass();
    test_r0();
    test_random();
    test_reset_sweep(-1, 1'b1);
    test_all_zero(0);
    test_fill();
    test_reset_sweep(16, 1'b0);
    test_all_zero(1);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL provide the following ports, clock and reset first:
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 wen_in  in  1  write enable from write-back stage.
REQ-005 waddr_in  in  `REG_ADDR_WIDTH  write register index.
REQ-006 wdata_in  in  `REG_DATA_WIDTH  write data.
REQ-007 ren1_in  in  1  read port 1 enable, driven by the decode stage's reg_rd_en1_out.
REQ-008 raddr1_in  in  `REG_ADDR_WIDTH  read port 1 index.
REQ-009 rdata1_out  out  `REG_DATA_WIDTH  read port 1 data, combinational.
REQ-010 ren2_in, raddr2_in, rdata2_out SHALL mirror port 1 for read port 2.
REQ-011 ready_out  out  1  high when the init sweep is complete and the file accepts reads and writes.

Function
REQ-012 Storage SHALL be 2^`REG_ADDR_WIDTH (32) words of `REG_DATA_WIDTH (32) bits.
REQ-013 FSM SHALL have states INIT and RUN; reset enters INIT with sweep counter = 0.
REQ-014 INIT SHALL write 0 to entry[counter] each cycle and increment the counter; after entry 31 is written, next state is RUN.
REQ-015 INIT SHALL last exactly 32 cycles after rst_n deasserts; ready_out SHALL rise on the 33rd rising edge after the reset edge.
REQ-016 In INIT, wen_in SHALL be ignored (write dropped, no deferred commit).
REQ-017 In INIT, rdata1_out and rdata2_out SHALL be 0.
REQ-018 In RUN, a write with wen_in=1 and waddr_in!=0 SHALL update the entry at the next rising edge; 1-cycle write latency.
REQ-019 A write to index 0 SHALL be discarded; entry 0 always reads 0.
REQ-020 In RUN, read data SHALL be combinational: 0 if renN_in=0 or raddrN_in=0; else wdata_in if wen_in=1 and waddr_in=raddrN_in (same-cycle write-through bypass); else the stored entry.
REQ-021 Both read ports MAY address the same index, including the write index, in the same cycle; both SHALL see identical data.
REQ-022 The sweep counter SHALL be `REG_ADDR_WIDTH bits, SHALL NOT wrap in RUN, and SHALL hold at its final value.
REQ-023 No output SHALL depend on X from uninitialised storage in any state.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force state INIT, counter 0, ready_out 0, regardless of current state, including mid-sweep and mid-RUN.
REQ-025 While rst_n=0, rdata1_out, rdata2_out and ready_out SHALL be 0, and no write SHALL commit.
REQ-026 Entries are not cleared in the reset cycle itself; clearing is by the INIT sweep only.

Structure
REQ-027 `REG_ADDR_WIDTH, `REG_DATA_WIDTH and the number of registers SHALL come from the shared defines file already used by the pipeline stages; the FSM state encoding SHALL be local to the block.
REQ-028 The block SHALL be a single module with no sub-modules; storage SHALL be inferable as distributed RAM (one write port, two asynchronous read ports).

Verification
REQ-029 Reset, then release -> ready_out=0 for 32 cycles, 1 on cycle 33; raddr1=5/ren1=1 returns 0 throughout and after.
REQ-030 RUN: write r3=0xDEADBEEF; next cycle, read r3 on both ports -> 0xDEADBEEF on both.
REQ-031 RUN: wen=1, waddr=7, wdata=0x12345678 with raddr1=7, ren1=1 in the same cycle -> rdata1_out=0x12345678 that cycle (bypass); ren2=0 -> rdata2_out=0.
REQ-032 Write r0=0xFFFFFFFF, including with simultaneous read of r0 -> rdata=0 in that cycle and afterwards.
REQ-033 Write during INIT (cycle 10, r4=0xA5A5A5A5) -> after ready_out, r4 reads 0.
REQ-034 Fill r1..r31 with index values, then pulse rst_n low mid-RUN and again at sweep cycle 16 -> ready_out drops, full 32-cycle sweep restarts, all entries read 0 afterwards.
